serializer: RTL and testbench
=============================

Name: serializer

Overview:
- Parallel-to-serial converter; sits directly upstream of the deserializer and drives its serial data/valid inputs.
- Accepts one word of DATA_W bits with a length field and emits the selected bits MSB-first, one bit per clock, with a per-bit valid.
- Raises busy while a transfer is in flight. New words are accepted only when idle.

Parameters:
- DATA_W, 16, parallel word width; must be >= 4.
- MOD_W, $clog2(DATA_W), width of the length field.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- arstn_i  input  1  reset, asynchronous, active-low.
- data_i  input  DATA_W  parallel word; bit DATA_W-1 is sent first.
- data_mod_i  input  MOD_W  number of valid bits, counted from the MSB; 0 means all DATA_W bits.
- data_val_i  input  1  data_i/data_mod_i valid this cycle.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o valid this cycle.
- busy_o  output  1  transfer in progress; input is ignored while high.

Behaviour:
- Reset: one clock clk_i; arstn_i is asynchronous and active-low.
  - While arstn_i=0, all state is cleared immediately, independent of clk_i.
  - Reset values: ser_data_o=0, ser_data_val_o=0, busy_o=0, FSM=IDLE, bit counter=0, shift register=0.
  - Deassertion takes effect at the next clk_i edge.
  - Reset mid-transfer aborts the word. No further bits are emitted, and the word is not resumed after reset.
- Length decode: len = DATA_W if data_mod_i==0, else len = data_mod_i.
- Illegal lengths: data_mod_i==1 or data_mod_i==2 is illegal. The word is dropped, busy_o stays 0 and no output is produced.
- FSM states:
  - IDLE: busy_o=0, ser_data_val_o=0, ser_data_o=0. On data_val_i=1 with a legal length:
    - capture data_i into the shift register;
    - load the counter with len-1;
    - go to SEND.
  - SEND: each cycle, ser_data_o = shift register MSB, ser_data_val_o=1, busy_o=1.
    - Shift left by one each cycle, zero-filling.
    - Decrement the counter each cycle; when it is 0 in this cycle (last bit), next state is IDLE.
- Latency: accept at edge of cycle N -> first bit valid in cycle N+1 -> last bit valid in cycle N+len.
  - busy_o is high in exactly cycles N+1..N+len, coincident with ser_data_val_o.
- Back-to-back: the earliest next accept is in cycle N+len+1, so its first bit is in cycle N+len+2. There is exactly one idle gap cycle between words.
- data_val_i while busy_o=1 is ignored; the word is not queued. Upstream must hold data_val_i until it sees busy_o=0.
- Inputs are sampled only in IDLE; changing data_i during SEND has no effect.
- ser_data_o is forced to 0 whenever ser_data_val_o=0.
- Counter width MOD_W+1, so len=DATA_W fits without overflow. No wrap-around is possible.

Decomposition:
- Package serializer_pkg holds:
  - state enum (IDLE, SEND);
  - default DATA_W constant;
  - MIN_LEN=3 constant used for the illegal-length check.
- Single module; no sub-module needed. Length decode is a small combinational function placed in the package (calc_len).

Test Plan:
- Reset: hold arstn_i=0 for 3 cycles with data_val_i=1 -> all outputs 0 throughout. After release, an accept occurs in the first cycle.
- Full word: data_i=16'hA5C3, data_mod_i=0, 1-cycle pulse -> bits 1010_0101_1100_0011 in cycles N+1..N+16; ser_data_val_o and busy_o high for exactly 16 cycles.
- Partial word: data_i=16'hF000, data_mod_i=5 -> bits 1,1,1,1,0 then idle; busy_o high 5 cycles.
- Illegal lengths: data_mod_i=1 and data_mod_i=2 -> busy_o and ser_data_val_o never assert.
  - Minimum legal length: data_mod_i=3 with data_i=16'h6000 -> bits 0,1,1.
- Busy and gap: data_val_i held high continuously with words 16'hFFFF and 16'h0001.
  - The second word is accepted only in the gap cycle after 16 bits of 1.
  - Exactly one cycle has ser_data_val_o=0 between the words; mid-transfer data_i changes do not corrupt output.
- Async reset mid-transfer: assert arstn_i low between clock edges at bit 7 of 16 -> outputs drop to 0 immediately (before the next edge).
  - After release, a new word 16'h8001 with data_mod_i=0 serializes correctly from its MSB.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
// Length decode lives here so every user agrees on what data_mod_i means.
package serializer_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int MIN_LEN    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A length field of zero selects the whole word.
  function automatic int calc_len(input int data_mod, input int data_w);
    return (data_mod == 0) ? data_w : data_mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: sends the top len bits of a word MSB-first,
// one bit per clock with a per-bit valid, and accepts a new word only when idle.
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // One extra bit so a full-word count never overflows.
  localparam int CNT_W = MOD_W + 1;

  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_next;
  logic [DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]   shift_next;

  int                  len;
  logic                accept;

  always_comb begin
    len    = calc_len(int'(data_mod_i), DATA_W);
    accept = (state_reg == IDLE) && data_val_i && (len >= MIN_LEN);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
          cnt_next   = CNT_W'(len - 1);
          shift_next = data_i;
        end
      end
      SEND: begin
        shift_next = {shift_reg[DATA_W-2:0], 1'b0};
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs depend only on registers, so an async reset clears them at once.
  always_comb begin
    busy_o         = (state_reg == SEND);
    ser_data_val_o = (state_reg == SEND);
    ser_data_o     = (state_reg == SEND) & shift_reg[DATA_W-1];
  end

endmodule

// File: tb/tb_serializer.sv
// Randomised scoreboard bench for serializer: a queue-based bit model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_serializer;

  localparam int W  = 16;
  localparam int MW = 4;

  logic          clk_i = 1'b0;
  logic          arstn_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic [MW-1:0] data_mod_i = '0;
  logic          data_val_i = 1'b0;
  logic          ser_data_o;
  logic          ser_data_val_o;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  serializer #(.DATA_W(W), .MOD_W(MW)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got busy,val,data=%b required %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits still to be sent sit in a queue; a word is taken
  // only when nothing is queued and the cycle just ending was not busy.
  logic         bits_q[$];
  logic [2:0]   exp_q[$];
  logic         cur_busy = 1'b0;
  int           m_len;
  logic         m_bit;

  always @(posedge clk_i) begin
    if (!arstn_i) begin
      bits_q.delete();
      cur_busy = 1'b0;
      exp_q.push_back(3'b000);
    end else begin
      if (bits_q.size() == 0 && !cur_busy && data_val_i) begin
        m_len = (data_mod_i == 0) ? W : int'(data_mod_i);
        if (m_len >= 3)
          for (int i = 0; i < m_len; i++) bits_q.push_back(data_i[W-1-i]);
      end
      if (bits_q.size() > 0) begin
        m_bit = bits_q.pop_front();
        cur_busy = 1'b1;
        exp_q.push_back({2'b11, m_bit});
      end else begin
        cur_busy = 1'b0;
        exp_q.push_back(3'b000);
      end
    end
  end

  logic [2:0] mon_exp;
  always @(negedge clk_i) begin
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue required an entry at t=%0t", $time);
    end else begin
      mon_exp = exp_q.pop_front();
      if (!arstn_i) mon_exp = 3'b000;
      check("cycle", {busy_o, ser_data_val_o, ser_data_o}, mon_exp);
    end
  end

  task automatic drive(input logic [W-1:0] d, input logic [MW-1:0] m, input logic v);
    @(negedge clk_i);
    #1;
    data_i     = d;
    data_mod_i = m;
    data_val_i = v;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [MW-1:0] m, input int gap);
    $display("word data=%h mod=%0d", d, m);
    drive(d, m, 1'b1);
    drive($urandom, $urandom, 1'b0);
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      #1;
      if (busy_o === lvl) return;
    end
    total++;
    bad++;
    $display("FAIL %s: got busy=%b required %b within %0d cycles", name, busy_o, lvl, budget);
  endtask

  initial begin
    // Reset held for 3 cycles while a word is offered; accept on release.
    data_i = 16'hA5C3;
    data_mod_i = '0;
    data_val_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    $display("word data=a5c3 mod=0 (offered through reset)");
    @(negedge clk_i);
    #1;
    data_val_i = 1'b0;
    repeat (18) @(negedge clk_i);

    send(16'hF000, 4'd5, 8);
    send(16'hFFFF, 4'd1, 6);
    send(16'hFFFF, 4'd2, 6);
    send(16'h6000, 4'd3, 6);

    // Held valid across two words: second is taken only in the gap cycle.
    $display("word data=ffff then 0001, valid held");
    drive(16'hFFFF, 4'd0, 1'b1);
    wait_busy(1'b1, 4, "first_accept");
    data_i = 16'h0001;
    wait_busy(1'b0, 20, "gap");
    wait_busy(1'b1, 3, "second_accept");
    data_val_i = 1'b0;
    repeat (17) begin
      @(negedge clk_i);
      #1;
      data_i = $urandom;
    end
    repeat (3) @(negedge clk_i);

    // Async reset between edges at bit 7 of 16.
    $display("word data=5a5a mod=0, reset at bit 7");
    drive(16'h5A5A, 4'd0, 1'b1);
    @(posedge clk_i);
    #1;
    data_val_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #2;
    arstn_i = 1'b0;
    #1;
    check("async_reset", {busy_o, ser_data_val_o, ser_data_o}, 3'b000);
    repeat (2) @(posedge clk_i);
    #1;
    data_i = 16'h8001;
    data_mod_i = '0;
    data_val_i = 1'b1;
    arstn_i = 1'b1;
    $display("word data=8001 mod=0 after reset");
    @(posedge clk_i);
    #1;
    data_val_i = 1'b0;
    repeat (18) @(negedge clk_i);

    // Random words, lengths (including illegal ones) and valid timing.
    for (int n = 0; n < 40; n++) begin
      data_i     = $urandom;
      data_mod_i = MW'($urandom_range(0, 15));
      $display("word data=%h mod=%0d random", data_i, data_mod_i);
      drive(data_i, data_mod_i, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      drive($urandom, $urandom, 1'b0);
      repeat ($urandom_range(0, 20)) @(negedge clk_i);
    end

    repeat (20) @(negedge clk_i);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
